// File: rtl/wb_pkg.sv
// Shared widths and register-write-data select encoding for the writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned REG_AW_DEFAULT = 5;

  // Encoding 3 is not listed and falls through to the ALU result.
  typedef enum logic [1:0] {
    REGSEL_ALU = 2'd0,
    REGSEL_HI  = 2'd1,
    REGSEL_LO  = 2'd2
  } regsel_e;

endpackage : wb_pkg

// File: rtl/writeback_stage_gpio_in_sync.sv
// Two-flop synchroniser that brings the asynchronous GPIO input into the clk domain.
module gpio_in_sync
  import wb_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule : gpio_in_sync

// File: rtl/writeback_stage.sv
// EX/WB stage: registers EX results, owns HI/LO and GPIO out, selects register-file
// write data and produces WB->EX forwarding flags.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_EX,
  input  logic              regwrite_EX,
  input  logic              enhilo_EX,
  input  logic [1:0]        regsel_EX,
  input  logic              rdrt_EX,
  input  logic              gpio_out_en_EX,
  input  logic              gpio_in_en_EX,
  input  logic [REG_AW-1:0] rs_EX,
  input  logic [REG_AW-1:0] rt_EX,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic [DATA_W-1:0] lo_EX,
  input  logic [DATA_W-1:0] hi_EX,
  input  logic [DATA_W-1:0] readdata2_EX,
  input  logic [DATA_W-1:0] gpio_in,
  output logic              regwrite_WB,
  output logic [REG_AW-1:0] writeaddr_WB,
  output logic [DATA_W-1:0] writedata_WB,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] gpio_out,
  output logic              fwd_rs,
  output logic              fwd_rt
);

  logic              regwrite_r;
  logic [REG_AW-1:0] waddr_r;
  logic [1:0]        regsel_r;
  logic              gpioin_r;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] gpio_sync;

  // Control bits are gated with valid_EX so a bubble never carries a write into WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_r <= 1'b0;
      waddr_r    <= '0;
      regsel_r   <= 2'd0;
      gpioin_r   <= 1'b0;
      alu_r      <= '0;
    end else begin
      regwrite_r <= valid_EX & regwrite_EX;
      waddr_r    <= rdrt_EX ? rt_EX : rd_EX;
      regsel_r   <= regsel_EX;
      gpioin_r   <= valid_EX & gpio_in_en_EX;
      alu_r      <= lo_EX;
    end
  end

  // Architectural HI/LO and GPIO output; both hold unless a valid instruction updates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      gpio_out <= '0;
    end else begin
      if (valid_EX && enhilo_EX) begin
        hi_q <= hi_EX;
        lo_q <= lo_EX;
      end
      if (valid_EX && gpio_out_en_EX) begin
        gpio_out <= readdata2_EX;
      end
    end
  end

  gpio_in_sync #(
    .W (DATA_W)
  ) u_gpio_in_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (gpio_sync)
  );

  // Write data select; MFHI/MFLO in WB see HI/LO before any same-cycle MULT update.
  always_comb begin
    writedata_WB = alu_r;
    if (gpioin_r) begin
      writedata_WB = gpio_sync;
    end else if (regsel_r == REGSEL_HI) begin
      writedata_WB = hi_q;
    end else if (regsel_r == REGSEL_LO) begin
      writedata_WB = lo_q;
    end
  end

  always_comb begin
    regwrite_WB  = regwrite_r & (waddr_r != '0);
    writeaddr_WB = waddr_r;
    fwd_rs       = regwrite_WB & (waddr_r == rs_EX);
    fwd_rt       = regwrite_WB & (waddr_r == rt_EX);
  end

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_EX, regwrite_EX, enhilo_EX, rdrt_EX;
  logic        gpio_out_en_EX, gpio_in_en_EX;
  logic [1:0]  regsel_EX;
  logic [4:0]  rs_EX, rt_EX, rd_EX;
  logic [31:0] lo_EX, hi_EX, readdata2_EX, gpio_in;
  logic        regwrite_WB, fwd_rs, fwd_rt;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB, hi_q, lo_q, gpio_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_EX       (valid_EX),
    .regwrite_EX    (regwrite_EX),
    .enhilo_EX      (enhilo_EX),
    .regsel_EX      (regsel_EX),
    .rdrt_EX        (rdrt_EX),
    .gpio_out_en_EX (gpio_out_en_EX),
    .gpio_in_en_EX  (gpio_in_en_EX),
    .rs_EX          (rs_EX),
    .rt_EX          (rt_EX),
    .rd_EX          (rd_EX),
    .lo_EX          (lo_EX),
    .hi_EX          (hi_EX),
    .readdata2_EX   (readdata2_EX),
    .gpio_in        (gpio_in),
    .regwrite_WB    (regwrite_WB),
    .writeaddr_WB   (writeaddr_WB),
    .writedata_WB   (writedata_WB),
    .hi_q           (hi_q),
    .lo_q           (lo_q),
    .gpio_out       (gpio_out),
    .fwd_rs         (fwd_rs),
    .fwd_rt         (fwd_rt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_EX       = 1'b0;
    regwrite_EX    = 1'b0;
    enhilo_EX      = 1'b0;
    regsel_EX      = 2'd0;
    rdrt_EX        = 1'b0;
    gpio_out_en_EX = 1'b0;
    gpio_in_en_EX  = 1'b0;
    rs_EX          = 5'd0;
    rt_EX          = 5'd0;
    rd_EX          = 5'd0;
    lo_EX          = 32'h0;
    hi_EX          = 32'h0;
    readdata2_EX   = 32'h0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
    bubble();
    valid_EX    = 1'b1;
    regwrite_EX = 1'b1;
    rd_EX       = rd;
    lo_EX       = res;
  endtask

  initial begin
    rst     = 1'b1;
    gpio_in = 32'h0;
    bubble();
    tick();
    tick();

    check("rst_regwrite", 32'(regwrite_WB), 32'h0);
    check("rst_waddr", 32'(writeaddr_WB), 32'h0);
    check("rst_wdata", writedata_WB, 32'h0);
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_fwd", {30'h0, fwd_rs, fwd_rt}, 32'h0);
    rst = 1'b0;

    // ADD rd=5
    alu_op(5'd5, 32'h7);
    tick();
    check("add_regwrite", 32'(regwrite_WB), 32'h1);
    check("add_waddr", 32'(writeaddr_WB), 32'd5);
    check("add_wdata", writedata_WB, 32'h7);

    // ADDI into rt=9
    alu_op(5'd3, 32'h10);
    rdrt_EX = 1'b1;
    rt_EX   = 5'd9;
    tick();
    check("addi_regwrite", 32'(regwrite_WB), 32'h1);
    check("addi_waddr", 32'(writeaddr_WB), 32'd9);
    check("addi_wdata", writedata_WB, 32'h10);

    // ADDI into rt=0: write suppressed, no forwarding even with rs/rt=0 in EX
    alu_op(5'd3, 32'h10);
    rdrt_EX = 1'b1;
    rt_EX   = 5'd0;
    tick();
    bubble();
    #1;
    check("r0_regwrite", 32'(regwrite_WB), 32'h0);
    check("r0_fwd", {30'h0, fwd_rs, fwd_rt}, 32'h0);

    // MULT, MFHI r4, MFLO r6
    bubble();
    valid_EX  = 1'b1;
    enhilo_EX = 1'b1;
    hi_EX     = 32'h1;
    lo_EX     = 32'hFFFF_FFFE;
    tick();
    check("mult_regwrite", 32'(regwrite_WB), 32'h0);
    check("mult_hi", hi_q, 32'h1);
    check("mult_lo", lo_q, 32'hFFFF_FFFE);
    alu_op(5'd4, 32'h0);
    regsel_EX = 2'd1;
    tick();
    check("mfhi_waddr", 32'(writeaddr_WB), 32'd4);
    check("mfhi_wdata", writedata_WB, 32'h1);
    alu_op(5'd6, 32'h0);
    regsel_EX = 2'd2;
    tick();
    check("mflo_waddr", 32'(writeaddr_WB), 32'd6);
    check("mflo_wdata", writedata_WB, 32'hFFFF_FFFE);

    // MFHI in WB while a new MULT sits in EX: WB sees the old HI
    alu_op(5'd4, 32'h0);
    regsel_EX = 2'd1;
    tick();
    bubble();
    valid_EX  = 1'b1;
    enhilo_EX = 1'b1;
    hi_EX     = 32'h77;
    lo_EX     = 32'h88;
    #1;
    check("mfhi_old_hi", writedata_WB, 32'h1);
    tick();
    check("mult2_hi", hi_q, 32'h77);
    check("mult2_lo", lo_q, 32'h88);

    // regsel=3 falls back to the ALU result
    alu_op(5'd10, 32'hCAFE);
    regsel_EX = 2'd3;
    tick();
    check("regsel3_wdata", writedata_WB, 32'hCAFE);

    // GPIO write, then held through bubbles that carry a stray enable
    bubble();
    valid_EX       = 1'b1;
    gpio_out_en_EX = 1'b1;
    readdata2_EX   = 32'hA5A5_0000;
    gpio_in        = 32'h1234;
    tick();
    check("gpio_out_wr", gpio_out, 32'hA5A5_0000);
    check("gpio_wr_noreg", 32'(regwrite_WB), 32'h0);
    for (int i = 0; i < 3; i++) begin
      bubble();
      gpio_out_en_EX = 1'b1;
      enhilo_EX      = 1'b1;
      readdata2_EX   = 32'hDEAD_BEEF;
      hi_EX          = 32'hDEAD_BEEF;
      tick();
      check("gpio_out_hold", gpio_out, 32'hA5A5_0000);
      check("hi_hold", hi_q, 32'h77);
    end

    // GPIO read into r2
    alu_op(5'd2, 32'hBEEF);
    gpio_in_en_EX = 1'b1;
    tick();
    check("gpio_rd_waddr", 32'(writeaddr_WB), 32'd2);
    check("gpio_rd_wdata", writedata_WB, 32'h1234);

    // Synchroniser latency: new gpio_in visible only after two edges
    gpio_in = 32'h5678;
    alu_op(5'd2, 32'h0);
    gpio_in_en_EX = 1'b1;
    tick();
    check("gpio_sync_1edge", writedata_WB, 32'h1234);
    tick();
    check("gpio_sync_2edge", writedata_WB, 32'h5678);

    // Forwarding from r7
    alu_op(5'd7, 32'h77);
    tick();
    alu_op(5'd8, 32'h0);
    rs_EX = 5'd7;
    rt_EX = 5'd7;
    #1;
    check("fwd_rs7", 32'(fwd_rs), 32'h1);
    check("fwd_rt7", 32'(fwd_rt), 32'h1);
    check("fwd_data", writedata_WB, 32'h77);
    rs_EX = 5'd7;
    rt_EX = 5'd3;
    #1;
    check("fwd_rt_miss", {30'h0, fwd_rs, fwd_rt}, 32'h2);

    // Bubble with unknown regwrite_EX
    bubble();
    regwrite_EX = 1'bx;
    rd_EX       = 5'd7;
    tick();
    check("bubble_regwrite", 32'(regwrite_WB), 32'h0);

    // Reset while MFHI is in WB
    bubble();
    valid_EX  = 1'b1;
    enhilo_EX = 1'b1;
    hi_EX     = 32'h55;
    lo_EX     = 32'h66;
    tick();
    alu_op(5'd4, 32'h0);
    regsel_EX = 2'd1;
    tick();
    check("pre_rst_wdata", writedata_WB, 32'h55);
    bubble();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_regwrite", 32'(regwrite_WB), 32'h0);
    check("mrst_waddr", 32'(writeaddr_WB), 32'h0);
    check("mrst_wdata", writedata_WB, 32'h0);
    check("mrst_hi", hi_q, 32'h0);
    check("mrst_lo", lo_q, 32'h0);
    check("mrst_gpio_out", gpio_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_writeback_stage

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- EX/WB pipeline stage directly downstream of the EX-stage control unit.
- Registers EX-stage control and ALU results, and owns the architectural HI/LO registers and the GPIO output register.
- Synchronises the GPIO input and selects the register-file write data (ALU, HI, LO or GPIO).
- Provides WB→EX forwarding flags and data for the two EX source operands.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_EX  in  1  EX holds a real instruction. 0 means bubble, which is driven during stall_FETCH.
- regwrite_EX  in  1  instruction writes the register file.
- enhilo_EX  in  1  MULT/MULTU: load HI/LO.
- regsel_EX  in  2  0 = ALU lo result, 1 = MFHI, 2 = MFLO, 3 = treated as 0.
- rdrt_EX  in  1  1 = destination rt, 0 = destination rd.
- gpio_out_en_EX  in  1  GPIO write (SRL with shamt 0).
- gpio_in_en_EX  in  1  GPIO read (SRA with shamt 0).
- rs_EX, rt_EX, rd_EX  in  REG_AW  EX instruction fields.
- lo_EX, hi_EX  in  DATA_W  ALU results.
- readdata2_EX  in  DATA_W  rt operand, the source for the GPIO write.
- gpio_in  in  DATA_W  asynchronous external input.
- regwrite_WB  out  1  register-file write enable.
- writeaddr_WB  out  REG_AW  register-file write address.
- writedata_WB  out  DATA_W  register-file write data.
- hi_q, lo_q  out  DATA_W  architectural HI/LO.
- gpio_out  out  DATA_W  registered GPIO output.
- fwd_rs, fwd_rt  out  1  forward writedata_WB to the corresponding EX operand.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything to 0: all WB pipeline registers, hi_q, lo_q, gpio_out and both synchroniser flops. This makes regwrite_WB=0, writeaddr_WB=0, writedata_WB=0, fwd_rs=fwd_rt=0. Reset applied mid-operation discards the instruction in WB; no register-file write occurs in that cycle.
- Pipeline capture, every edge with rst=0, no enable:
  - regwrite_r <= valid_EX & regwrite_EX.
  - waddr_r <= rdrt_EX ? rt_EX : rd_EX.
  - regsel_r <= regsel_EX.
  - gpioin_r <= valid_EX & gpio_in_en_EX.
  - alu_r <= lo_EX.
  - Latency EX→WB is 1 cycle.
- regwrite_WB = regwrite_r & (waddr_r != 0). Writes to r0 are suppressed.
- writeaddr_WB = waddr_r.
- writedata_WB, combinational from WB state, priority order:
  1. gpioin_r → gpio_sync.
  2. regsel_r == 1 → hi_q.
  3. regsel_r == 2 → lo_q.
  4. otherwise → alu_r.
- HI/LO update: on an edge with valid_EX & enhilo_EX, hi_q <= hi_EX and lo_q <= lo_EX; otherwise they hold. MULT in EX at cycle n followed by MFHI in EX at n+1 returns the new HI in WB at n+2 (no hazard).
- Same-cycle MULT in EX and MFHI/MFLO in WB: WB sees the pre-update hi_q/lo_q, which is correct program order.
- GPIO out: on an edge with valid_EX & gpio_out_en_EX, gpio_out <= readdata2_EX; otherwise it holds. The register-file write of that instruction proceeds normally per regwrite_EX.
- GPIO in: two-flop synchroniser, gpio_sync = second flop. The value seen in WB is gpio_in as it was 2 edges earlier.
- Forwarding, combinational:
  - fwd_rs = regwrite_WB & (waddr_r == rs_EX).
  - fwd_rt = regwrite_WB & (waddr_r == rt_EX).
  - Never asserted for address 0.
- Bubble (valid_EX=0): no register-file write, HI/LO hold, gpio_out holds. X values on the other control inputs must not propagate to any state. regsel_r may capture X, but writedata_WB is don't-care while regwrite_WB=0.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and REG_AW defaults.
  - regsel enum: REGSEL_ALU=0, REGSEL_HI=1, REGSEL_LO=2.
- One sub-module, gpio_in_sync: 2-flop synchroniser with synchronous active-high reset to 0, width DATA_W.

Test Plan:
- ADD to rd=5, lo_EX=0x0000_0007, valid → next cycle regwrite_WB=1, writeaddr_WB=5, writedata_WB=7.
- ADDI with rdrt_EX=1, rt=9, rd=3, lo_EX=0x10 → writeaddr_WB=9, writedata_WB=0x10. Same instruction with rt=0 → regwrite_WB=0, fwd_rs=fwd_rt=0.
- MULT hi_EX=0x1, lo_EX=0xFFFF_FFFE, then MFHI rd=4, then MFLO rd=6 → WB writes 0x1 to r4, then 0xFFFF_FFFE to r6. regwrite_WB=0 during the MULT's WB cycle.
- GPIO write readdata2_EX=0xA5A5_0000 → gpio_out=0xA5A5_0000 after 1 edge, held through 3 bubbles. gpio_in=0x1234 held stable, then GPIO read rd=2 → writedata_WB=0x1234.
- WB writing r7 while EX has rs=7, rt=7 → fwd_rs=fwd_rt=1 and writedata_WB matches the r7 result. A bubble with regwrite_EX=X and valid_EX=0 → regwrite_WB=0.
- Assert rst for 1 cycle while MFHI is in WB with hi_q=0x55 → next cycle all outputs 0, hi_q=0, gpio_out=0, no write.
